// File: rtl/square_calc.sv
`default_nettype none
// ============================================================================
// Module   : square_calc
// Purpose  : Iterative squarer. Sums the first N odd numbers to form N*N,
//            with a start/ready handshake for cross-checking root results.
// Revision : 1.0  initial release
// ============================================================================
module square_calc #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 2 * IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  valor_i,
    input  logic             start_i,
    output logic [OUT_W-1:0] square_o,
    output logic             ready_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IN_W-1:0] c_cnt_one = IN_W'(1);
    localparam logic [IN_W:0]   c_odd_one = (IN_W+1)'(1);
    localparam logic [IN_W:0]   c_odd_two = (IN_W+1)'(2);

    state_t            r_state;
    state_t            w_next;
    logic [IN_W-1:0]   r_op;
    logic [IN_W-1:0]   r_cnt;
    logic [IN_W:0]     r_odd;
    logic [OUT_W-1:0]  r_acc;
    logic [OUT_W-1:0]  r_square;

    logic              w_accept;
    logic              w_last;
    logic [OUT_W-1:0]  w_sum;

    assign w_accept = (r_state == IDLE) && start_i;
    // The edge that performs the N-th addition is the one where cnt reaches N-1.
    assign w_last   = (r_cnt == (r_op - c_cnt_one));
    assign w_sum    = r_acc + OUT_W'(r_odd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next = (valor_i != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_odd    <= '0;
            r_acc    <= '0;
            r_square <= '0;
        end else if (w_accept) begin
            r_op  <= valor_i;
            r_cnt <= '0;
            r_odd <= c_odd_one;
            r_acc <= '0;
            // A zero operand never enters ACC, so its result is produced here.
            if (valor_i == '0) begin
                r_square <= '0;
            end
        end else if (r_state == ACC) begin
            r_acc <= w_sum;
            r_odd <= r_odd + c_odd_two;
            r_cnt <= r_cnt + c_cnt_one;
            if (w_last) begin
                r_square <= w_sum;
            end
        end
    end

    assign square_o = r_square;
    assign ready_o  = (r_state == DONE);
    assign busy_o   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_square_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_square_calc
// Purpose  : Directed self-checking bench for square_calc.
// Revision : 1.0  initial release
// ============================================================================
module tb_square_calc;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [IN_W-1:0]  valor_i;
    logic             start_i;
    logic [OUT_W-1:0] square_o;
    logic             ready_o;
    logic             busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    square_calc #(.IN_W(IN_W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valor_i  (valor_i),
        .start_i  (start_i),
        .square_o (square_o),
        .ready_o  (ready_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Counts falling edges until ready_o is seen; cycles=1 means the cycle after the accept edge.
    task automatic wait_ready(output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 600) begin
            @(negedge clk);
            cycles++;
            if (ready_o) seen = 1'b1;
        end
    endtask

    // Issues a single-cycle start from IDLE at a falling edge.
    task automatic launch(input logic [IN_W-1:0] n);
        valor_i = n;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic run_single(input string tag, input int n);
        int cyc;
        bit seen;
        launch(n[IN_W-1:0]);
        wait_ready(cyc, seen);
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(n + 1));
        check({tag, "_square"}, 32'(square_o), 32'(n * n));
        @(negedge clk);
        check({tag, "_ready_drop"}, 32'(ready_o), 32'd0);
        check({tag, "_hold"}, 32'(square_o), 32'(n * n));
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  pulses;

        rst_n   = 1'b0;
        start_i = 1'b0;
        valor_i = '0;
        repeat (3) @(negedge clk);
        check("rst_square", 32'(square_o), 32'd0);
        check("rst_ready",  32'(ready_o),  32'd0);
        check("rst_busy",   32'(busy_o),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: N=0 - busy for exactly one cycle, ready in that same cycle
        launch(8'd7);
        wait_ready(cyc, seen);
        @(negedge clk);
        valor_i = 8'd0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        check("t1_ready", 32'(ready_o), 32'd1);
        check("t1_busy",  32'(busy_o),  32'd1);
        check("t1_square", 32'(square_o), 32'd0);
        @(negedge clk);
        check("t1_busy_drop", 32'(busy_o), 32'd0);

        // T2
        run_single("t2_n15", 15);
        run_single("t2_n1", 1);

        // T3: largest operand
        run_single("t3_n255", 255);

        // T4: start during ACC is ignored
        valor_i = 8'd10;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        pulses  = 0;
        cyc     = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 4) begin
                valor_i = 8'd3;
                start_i = 1'b1;
            end
            if (i == 5) start_i = 1'b0;
            if (i == 1) check("t4_busy", 32'(busy_o), 32'd1);
            if (ready_o) begin
                pulses++;
                if (pulses == 1) begin
                    cyc = i;
                    check("t4_square", 32'(square_o), 32'd100);
                end
            end
        end
        check("t4_latency", 32'(cyc), 32'd11);
        check("t4_pulses",  32'(pulses), 32'd1);

        // T5: asynchronous abort mid-operation
        launch(8'd200);
        repeat (50) @(negedge clk);
        check("t5_busy_pre", 32'(busy_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_square_rst", 32'(square_o), 32'd0);
        check("t5_ready_rst",  32'(ready_o),  32'd0);
        check("t5_busy_rst",   32'(busy_o),   32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (ready_o || busy_o) pulses++;
        end
        check("t5_no_ready", 32'(pulses), 32'd0);
        run_single("t5_n7", 7);

        // T6: start held high, sweep every operand
        @(negedge clk);
        valor_i = 8'd0;
        start_i = 1'b1;
        for (int n = 0; n < 256; n++) begin
            wait_ready(cyc, seen);
            check("t6_seen", 32'(seen), 32'd1);
            check($sformatf("t6_square_%0d", n), 32'(square_o), 32'(n * n));
            check($sformatf("t6_spacing_%0d", n), 32'(cyc), (n == 0) ? 32'd1 : 32'(n + 2));
            if (!seen) break;
            valor_i = 8'(n + 1);
        end
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_idle", 32'(busy_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
